// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - default rates and tick-divide helper for the button conditioner
package btn_pkg;

    localparam int DEF_CLK_HZ    = 100_000_000;
    localparam int DEF_SAMPLE_HZ = 100_000;
    localparam int DEF_DEPTH     = 8;

    function automatic int f_count(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one debounce channel; hold counter and o_long built under BTN_LONGPRESS_EN
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LONG_TICKS = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    if (LONG_TICKS < 1) begin : g_bad_long_ticks
        $fatal(1, "btn_debounce_ch: LONG_TICKS must be >= 1");
    end

    logic             sync1;
    logic             sync2;
    logic [DEPTH-1:0] shreg;
    logic             all_ones;
    logic             all_zeros;

    // Synchroniser runs every clock; only the shift register is tick-gated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (tick) begin
            shreg <= {shreg[DEPTH-2:0], sync2};
        end
    end

    assign all_ones  = &shreg;
    assign all_zeros = ~|shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            if (all_ones && !o_level) begin
                o_level <= 1'b1;
                o_press <= 1'b1;
            end else if (all_zeros && o_level) begin
                o_level   <= 1'b0;
                o_release <= 1'b1;
            end
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam int            HW        = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    logic [HW-1:0] hold_cnt;

    // Saturating at HOLD_MAX keeps o_long from repeating until the level drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            o_long   <= 1'b0;
        end else begin
            o_long <= o_level && tick && (hold_cnt == HOLD_LAST);
            if (!o_level) begin
                hold_cnt <= '0;
            end else if (tick && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - multi-channel button debouncer top; long-press pulses built under BTN_LONGPRESS_EN
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int SAMPLE_HZ  = DEF_SAMPLE_HZ,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_BTN    = 4,
    parameter int LONG_TICKS = 50_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long
);

    localparam int            F_COUNT  = f_count(CLK_HZ, SAMPLE_HZ);
    localparam int            CW       = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(F_COUNT - 1);

    if (CLK_HZ % SAMPLE_HZ != 0) begin : g_bad_ratio
        $fatal(1, "btn_debounce_multi: CLK_HZ must be a multiple of SAMPLE_HZ");
    end
    if (F_COUNT < 2) begin : g_bad_fcount
        $fatal(1, "btn_debounce_multi: F_COUNT must be >= 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "btn_debounce_multi: DEPTH must be >= 2");
    end
    if (NUM_BTN < 1) begin : g_bad_num
        $fatal(1, "btn_debounce_multi: NUM_BTN must be >= 1");
    end

    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    for (genvar k = 0; k < NUM_BTN; k++) begin : g_ch
        btn_debounce_ch #(
            .DEPTH      (DEPTH),
            .LONG_TICKS (LONG_TICKS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .i_btn     (i_btn[k]),
            .o_level   (o_level[k]),
            .o_press   (o_press[k]),
            .o_release (o_release[k]),
            .o_long    (o_long[k])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - self-checking bench for btn_debounce_multi against a run-length model
module tb_btn_debounce_multi;

    localparam int CLK_HZ     = 1000;
    localparam int SAMPLE_HZ  = 100;
    localparam int DEPTH      = 4;
    localparam int NUM_BTN    = 2;
    localparam int LONG_TICKS = 5;
    localparam int F          = CLK_HZ / SAMPLE_HZ;
`ifdef BTN_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] i_btn = 2'b00;
    logic [1:0] o_level;
    logic [1:0] o_press;
    logic [1:0] o_release;
    logic [1:0] o_long;

    btn_debounce_multi #(
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_HZ  (SAMPLE_HZ),
        .DEPTH      (DEPTH),
        .NUM_BTN    (NUM_BTN),
        .LONG_TICKS (LONG_TICKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_btn     (i_btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference: level follows runs of DEPTH equal tick samples of the input seen two clocks late.
    int         m_edge;
    logic [1:0] m_d1, m_d2;
    int         m_ones[2], m_zeros[2], m_hold[2];
    logic [1:0] m_level, m_press, m_release, m_long;

    int cyc = 0;
    int n_press[2], n_release[2], n_long[2];
    int t_press0, t_release0, t_long0;
    int both_seen;
    int start;

    task automatic check_v(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_i(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_edge    = 0;
        m_d1      = 2'b00;
        m_d2      = 2'b00;
        m_level   = 2'b00;
        m_press   = 2'b00;
        m_release = 2'b00;
        m_long    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            m_ones[k]  = 0;
            m_zeros[k] = DEPTH;
            m_hold[k]  = 0;
        end
    endtask

    task automatic model_step();
        logic [1:0] nl;
        bit         shift;
        m_edge++;
        shift = ((m_edge % F) == 0);
        for (int k = 0; k < 2; k++) begin
            nl[k] = m_level[k];
            if (m_ones[k] >= DEPTH) nl[k] = 1'b1;
            else if (m_zeros[k] >= DEPTH) nl[k] = 1'b0;
            m_press[k]   = nl[k] & ~m_level[k];
            m_release[k] = ~nl[k] & m_level[k];
            m_long[k]    = 1'b0;
            if (!m_level[k]) begin
                m_hold[k] = 0;
            end else if (shift && m_hold[k] < LONG_TICKS) begin
                m_hold[k]++;
                m_long[k] = LONG_EN && (m_hold[k] == LONG_TICKS);
            end
            if (shift) begin
                if (m_d2[k]) begin
                    m_ones[k]++;
                    m_zeros[k] = 0;
                end else begin
                    m_zeros[k]++;
                    m_ones[k] = 0;
                end
            end
        end
        m_level = nl;
        m_d2    = m_d1;
        m_d1    = i_btn;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            n_press[k]   = 0;
            n_release[k] = 0;
            n_long[k]    = 0;
        end
        t_press0   = -1;
        t_release0 = -1;
        t_long0    = -1;
        both_seen  = 0;
        start      = cyc;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        cyc++;
        check_v("level", o_level, m_level);
        check_v("press", o_press, m_press);
        check_v("release", o_release, m_release);
        check_v("long", o_long, m_long);
        for (int k = 0; k < 2; k++) begin
            n_press[k]   += int'(o_press[k]);
            n_release[k] += int'(o_release[k]);
            n_long[k]    += int'(o_long[k]);
        end
        if (o_press[0] && t_press0 < 0) t_press0 = cyc;
        if (o_release[0] && t_release0 < 0) t_release0 = cyc;
        if (o_long[0] && t_long0 < 0) t_long0 = cyc;
        if (o_press == 2'b11) both_seen = 1;
    endtask

    initial begin
        model_reset();
        clear_counts();
        repeat (3) cycle();
        check_v("reset_level", o_level, 2'b00);
        check_v("reset_pulses", o_press | o_release | o_long, 2'b00);
        reset = 1'b1;

        // Clean press on channel 0
        clear_counts();
        i_btn = 2'b01;
        repeat (60) cycle();
        check_i("press0_count", n_press[0], 1);
        check_i("press0_latency_ok", int'(t_press0 > start && t_press0 - start <= 43), 1);
        check_v("press0_level", o_level, 2'b01);
        check_i("ch1_quiet", n_press[1] + n_release[1] + n_long[1], 0);

        // Release
        clear_counts();
        i_btn = 2'b00;
        repeat (60) cycle();
        check_i("release0_count", n_release[0], 1);
        check_i("release0_latency_ok", int'(t_release0 > start && t_release0 - start <= 43), 1);
        check_v("release0_level", o_level, 2'b00);

        // Bounce: toggle every 15 clk for 200 clk, then settle high
        clear_counts();
        for (int c = 0; c < 200; c++) begin
            if (c % 15 == 0) i_btn[0] = ~i_btn[0];
            cycle();
        end
        check_i("bounce_no_release", n_release[0], 0);
        check_i("bounce_no_early_press", n_press[0], 0);
        i_btn[0] = 1'b1;
        repeat (60) cycle();
        check_i("bounce_press_count", n_press[0], 1);
        check_i("bounce_release_count", n_release[0], 0);

        i_btn = 2'b00;
        repeat (60) cycle();

        // Simultaneous press
        clear_counts();
        i_btn = 2'b11;
        repeat (60) cycle();
        check_i("simultaneous_press", both_seen, 1);
        check_v("simultaneous_level", o_level, 2'b11);

        i_btn = 2'b00;
        repeat (60) cycle();

        // Long press: hold for 100 ticks
        clear_counts();
        i_btn = 2'b01;
        repeat (100 * F) cycle();
        check_i("long_press_count", n_press[0], 1);
        check_i("long0_count", n_long[0], LONG_EN ? 1 : 0);
        check_i("long1_count", n_long[1], 0);
        check_i("long_delay_ok",
                LONG_EN ? int'(t_long0 - t_press0 >= 4 * F && t_long0 - t_press0 <= 6 * F)
                        : int'(t_long0 == -1), 1);

        // Reset while held
        check_v("pre_reset_level", o_level, 2'b01);
        reset = 1'b0;
        #1;
        check_v("async_reset_level", o_level, 2'b00);
        check_v("async_reset_pulses", o_press | o_release | o_long, 2'b00);
        model_reset();
        repeat (5) cycle();
        reset = 1'b1;
        clear_counts();
        repeat (60) cycle();
        check_i("repress_after_reset", n_press[0], 1);
        check_v("repress_level", o_level, 2'b01);

        // Randomised holds with short glitches, checked cycle by cycle against the model
        for (int s = 0; s < 12; s++) begin
            int hold;
            i_btn = 2'($urandom_range(0, 3));
            hold  = $urandom_range(5, 90);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 15) == 0) i_btn[$urandom_range(0, 1)] ^= 1'b1;
                cycle();
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner that replaces the single-channel debouncer in the counter and stopwatch designs. Each of NUM_BTN raw button inputs is synchronised and sampled on a shared enable tick derived from the system clock, which replaces the derived-clock approach. Each input is filtered with a symmetric DEPTH-sample stability window. Per channel, the block outputs a stable level, one-cycle press and release pulses and, optionally, a one-cycle long-press pulse.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- SAMPLE_HZ, 100_000: sample tick rate; F_COUNT = CLK_HZ/SAMPLE_HZ.
- DEPTH, 8: consecutive equal samples required to change the stable level.
- NUM_BTN, 4: number of independent channels.
- LONG_TICKS, 50_000: sample ticks of continuous stable-high before o_long fires. Only used with the long-press feature.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset; one clock, no other clock domains.
- i_btn  in  NUM_BTN  raw, asynchronous button inputs, active-high.
- o_level  out  NUM_BTN  debounced stable level per channel.
- o_press  out  NUM_BTN  one-clk pulse on stable 0→1.
- o_release  out  NUM_BTN  one-clk pulse on stable 1→0.
- o_long  out  NUM_BTN  one-clk pulse at long-press threshold. Tied 0 when the feature is compiled out.

## Operation
- Tick generator, shared by all channels:
  - Counter 0..F_COUNT-1, width $clog2(F_COUNT).
  - tick = 1 for exactly one clk when the counter equals F_COUNT-1; the counter wraps to 0 on that cycle.
- Per channel, input path:
  - 2-FF synchroniser on i_btn[k]; these flops clock every cycle, not only on tick.
  - DEPTH-bit shift register shifts in the synchronised bit on tick only.
- Per channel, level update:
  - Shift register all 1s and o_level=0: o_level←1 and o_press←1 in the same edge.
  - Shift register all 0s and o_level=1: o_level←0 and o_release←1 in the same edge.
  - Otherwise o_level holds (hysteresis), and o_press/o_release←0.
- Press and release pulses are registered, last exactly one clk, and never coincide on one channel.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- Long-press counter, per channel:
  - Width $clog2(LONG_TICKS+1).
  - Cleared while o_level=0.
  - While o_level=1, increments on tick and saturates at LONG_TICKS.
  - o_long pulses one clk on the tick that makes the count equal LONG_TICKS.
  - No repeat until release and re-press.
- Elaboration checks, fatal on violation:
  - CLK_HZ % SAMPLE_HZ == 0
  - F_COUNT ≥ 2
  - DEPTH ≥ 2
  - NUM_BTN ≥ 1
  - LONG_TICKS ≥ 1

## Timing
- Reset, while low and asynchronously on assertion:
  - Tick counter, synchronisers, shift registers and hold counters = 0.
  - o_level, o_press, o_release, o_long = 0.
- Reset release: first tick occurs F_COUNT clks after the first active edge.
- Press latency, from i_btn going high and staying high:
  - 2 clk synchroniser, then DEPTH ticks, then o_level/o_press on the same edge as the DEPTH-th qualifying tick's shift plus 1 clk.
  - Worst case ≈ 2 + DEPTH·F_COUNT + 1 clk.
- Release latency: symmetric to press latency.
- Glitches or bounce shorter than DEPTH consecutive ticks produce no output change.
- o_long asserts LONG_TICKS ticks after o_press, ±1 tick.
- Reset mid-operation: all state is discarded; a held button re-qualifies from scratch after reset release, producing a fresh o_press.

## Configuration
- BTN_LONGPRESS_EN defined: hold counters and o_long logic are built.
- BTN_LONGPRESS_EN undefined:
  - No hold counters are instantiated.
  - o_long is driven constant 0.
  - LONG_TICKS is ignored.
  - All other behaviour is identical.

## Structure
- Package btn_pkg: function f_count(clk_hz, sample_hz), and the default constants for CLK_HZ, SAMPLE_HZ and DEPTH.
- Sub-module btn_debounce_ch:
  - Contains one channel: synchroniser, shift register, level/pulse registers and optional hold counter.
  - Takes clk, reset, tick and i_btn bit.
  - Instantiated NUM_BTN times in a generate loop.
- The tick generator lives in the top module.

## Test plan
Use CLK_HZ=1000, SAMPLE_HZ=100 (F_COUNT=10), DEPTH=4, NUM_BTN=2, LONG_TICKS=5.
- Clean press: i_btn[0] 0→1, held.
  - o_level[0]=1 and a single 1-clk o_press[0] within 2+40+1 clk.
  - Channel 1 outputs stay 0.
- Bounce: i_btn[0] toggles every 15 clk for 200 clk, then settles high.
  - Exactly one o_press[0], and no o_release[0] during the bounce.
- Release: settled high, then 0.
  - One o_release[0] within 43 clk; o_level[0]=0.
- Simultaneous: both inputs rise on the same clk.
  - o_press=2'b11 in the same cycle.
- Long press (macro defined): hold high for 100 ticks.
  - Exactly one o_long[0], 5 ticks after o_press[0].
  - Macro undefined: o_long stays 0.
- Reset mid-hold: assert reset while o_level[0]=1.
  - All outputs go 0 immediately.
  - After release with the input still high, a new o_press[0] appears.
